// File: rtl/sdram_arbit.sv
// rtl/sdram_arbit.sv - SDRAM command arbiter between init, refresh, write and read engines
// Priority refresh > write > read; the owner holds the bus until its own end strobe.
module sdram_arbit #(
    parameter int          DQ_W    = 16,
    parameter logic [17:0] NOP_CMD = 18'h1c000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            init_end,
    input  logic [17:0]     init_cmd,
    input  logic            ref_req,
    output logic            ref_en,
    input  logic [17:0]     ref_cmd,
    input  logic            ref_end,
    input  logic            w_req,
    output logic            w_en,
    input  logic [17:0]     w_cmd,
    input  logic [DQ_W-1:0] w_dq,
    input  logic            write_ref_break_end,
    input  logic            write_data_end,
    input  logic            r_req,
    output logic            r_en,
    input  logic [17:0]     r_cmd,
    input  logic            read_ref_break_end,
    input  logic            read_data_end,
    output logic            sdram_cs_n,
    output logic            sdram_ras_n,
    output logic            sdram_cas_n,
    output logic            sdram_we_n,
    output logic [1:0]      sdram_ba,
    output logic [11:0]     sdram_addr,
    output logic [DQ_W-1:0] sdram_dq_out,
    output logic            sdram_dq_oe
);

    typedef enum logic [4:0] {
        INIT  = 5'b00001,
        ARBIT = 5'b00010,
        AREF  = 5'b00100,
        WRITE = 5'b01000,
        READ  = 5'b10000
    } state_t;

    state_t            state_q, state_d;
    logic [17:0]       cmd_q, cmd_d;
    logic [DQ_W-1:0]   dq_q;
    logic              dq_oe_q;
    logic              ref_en_q, w_en_q, r_en_q;
    logic              ref_en_d, w_en_d, r_en_d;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            INIT:  if (init_end) state_d = ARBIT;
            ARBIT: begin
                if (ref_req)     state_d = AREF;
                else if (w_req)  state_d = WRITE;
                else if (r_req)  state_d = READ;
            end
            AREF:  if (ref_end) state_d = ARBIT;
            WRITE: if (write_data_end || write_ref_break_end) state_d = ARBIT;
            READ:  if (read_data_end || read_ref_break_end) state_d = ARBIT;
            default: state_d = INIT;
        endcase
    end

    // Grants mirror the ARBIT decision so they fire on the edge that leaves ARBIT.
    always_comb begin
        ref_en_d = (state_q == ARBIT) && ref_req;
        w_en_d   = (state_q == ARBIT) && !ref_req && w_req;
        r_en_d   = (state_q == ARBIT) && !ref_req && !w_req && r_req;
    end

    always_comb begin
        cmd_d = NOP_CMD;
        unique case (state_q)
            INIT:    cmd_d = init_cmd;
            AREF:    cmd_d = ref_cmd;
            WRITE:   cmd_d = w_cmd;
            READ:    cmd_d = r_cmd;
            default: cmd_d = NOP_CMD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= INIT;
            cmd_q    <= NOP_CMD;
            dq_q     <= '0;
            dq_oe_q  <= 1'b0;
            ref_en_q <= 1'b0;
            w_en_q   <= 1'b0;
            r_en_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            dq_q     <= w_dq;
            dq_oe_q  <= (state_q == WRITE);
            ref_en_q <= ref_en_d;
            w_en_q   <= w_en_d;
            r_en_q   <= r_en_d;
        end
    end

    assign ref_en       = ref_en_q;
    assign w_en         = w_en_q;
    assign r_en         = r_en_q;
    assign sdram_cs_n   = cmd_q[17];
    assign sdram_ras_n  = cmd_q[16];
    assign sdram_cas_n  = cmd_q[15];
    assign sdram_we_n   = cmd_q[14];
    assign sdram_ba     = cmd_q[13:12];
    assign sdram_addr   = cmd_q[11:0];
    assign sdram_dq_out = dq_q;
    assign sdram_dq_oe  = dq_oe_q;

endmodule

// File: tb/tb_sdram_arbit.sv
// tb/tb_sdram_arbit.sv - randomized self-checking bench for sdram_arbit
// Owner-based reference model predicts grants, pins and DQ every cycle.
module tb_sdram_arbit;

    localparam int          DQ_W = 16;
    localparam logic [17:0] NOP  = 18'h1c000;

    logic            clk = 1'b0;
    logic            rst;
    logic            init_end;
    logic [17:0]     init_cmd, ref_cmd, w_cmd, r_cmd;
    logic            ref_req, ref_end, w_req, r_req;
    logic            write_ref_break_end, write_data_end;
    logic            read_ref_break_end, read_data_end;
    logic [DQ_W-1:0] w_dq;
    logic            ref_en, w_en, r_en;
    logic            sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic [1:0]      sdram_ba;
    logic [11:0]     sdram_addr;
    logic [DQ_W-1:0] sdram_dq_out;
    logic            sdram_dq_oe;

    int n_tests = 0;
    int n_fail  = 0;

    // Bus owner: 0 init, 1 arbitrating, 2 refresh, 3 write, 4 read
    int owner;

    sdram_arbit #(.DQ_W(DQ_W), .NOP_CMD(NOP)) dut (
        .clk(clk), .rst(rst), .init_end(init_end), .init_cmd(init_cmd),
        .ref_req(ref_req), .ref_en(ref_en), .ref_cmd(ref_cmd), .ref_end(ref_end),
        .w_req(w_req), .w_en(w_en), .w_cmd(w_cmd), .w_dq(w_dq),
        .write_ref_break_end(write_ref_break_end), .write_data_end(write_data_end),
        .r_req(r_req), .r_en(r_en), .r_cmd(r_cmd),
        .read_ref_break_end(read_ref_break_end), .read_data_end(read_data_end),
        .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n), .sdram_cas_n(sdram_cas_n),
        .sdram_we_n(sdram_we_n), .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
        .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] pins();
        return {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr};
    endfunction

    task automatic clear_strobes();
        ref_end = 0; write_ref_break_end = 0; write_data_end = 0;
        read_ref_break_end = 0; read_data_end = 0;
    endtask

    // One clock: predict from the current owner and inputs, clock, then compare.
    task automatic step();
        logic [17:0]     e_cmd;
        logic [DQ_W-1:0] e_dq;
        logic            e_oe, e_ref, e_w, e_r;
        int              nxt;
        e_ref = (owner == 1) && ref_req;
        e_w   = (owner == 1) && !ref_req && w_req;
        e_r   = (owner == 1) && !ref_req && !w_req && r_req;
        case (owner)
            0: e_cmd = init_cmd;
            2: e_cmd = ref_cmd;
            3: e_cmd = w_cmd;
            4: e_cmd = r_cmd;
            default: e_cmd = NOP;
        endcase
        e_oe = (owner == 3);
        e_dq = w_dq;
        nxt  = owner;
        if (owner == 0 && init_end) nxt = 1;
        else if (owner == 1) nxt = ref_req ? 2 : w_req ? 3 : r_req ? 4 : 1;
        else if (owner == 2 && ref_end) nxt = 1;
        else if (owner == 3 && (write_data_end || write_ref_break_end)) nxt = 1;
        else if (owner == 4 && (read_data_end || read_ref_break_end)) nxt = 1;
        if (rst) begin
            e_ref = 0; e_w = 0; e_r = 0; e_cmd = NOP; e_oe = 0; e_dq = '0; nxt = 0;
        end
        @(posedge clk);
        #1;
        check("ref_en", 32'(ref_en), 32'(e_ref));
        check("w_en",   32'(w_en),   32'(e_w));
        check("r_en",   32'(r_en),   32'(e_r));
        check("cmd",    32'(pins()), 32'(e_cmd));
        check("dq_oe",  32'(sdram_dq_oe), 32'(e_oe));
        check("dq_out", 32'(sdram_dq_out), 32'(e_dq));
        check("onehot", 32'(int'(ref_en) + int'(w_en) + int'(r_en) <= 1), 32'd1);
        owner = nxt;
    endtask

    initial begin
        owner = 0;
        rst = 1; init_end = 0;
        init_cmd = 18'h08400; ref_cmd = 18'h04000; w_cmd = 18'h10004; r_cmd = 18'h14008;
        ref_req = 0; w_req = 0; r_req = 0; w_dq = 16'hbeef;
        clear_strobes();

        // Reset state
        @(posedge clk); #1;
        check("rst_cmd", 32'(pins()), 32'(NOP));
        check("rst_oe", 32'(sdram_dq_oe), 32'd0);
        check("rst_dq", 32'(sdram_dq_out), 32'd0);
        check("rst_grants", {29'd0, ref_en, w_en, r_en}, 32'd0);
        step();
        rst = 0;

        // Requests ignored until init_end
        w_req = 1; ref_req = 1;
        for (int i = 0; i < 8; i++) step();
        init_end = 1; ref_req = 0;
        step();
        check("init_cmd_on_pins", 32'(pins()), 32'h08400);
        step();
        check("w_grant", 32'(w_en), 32'd1);
        w_req = 0;
        step();
        check("w_cmd_on_pins", 32'(pins()), 32'h10004);
        check("w_oe", 32'(sdram_dq_oe), 32'd1);
        read_data_end = 1;          // foreign strobe: must stay WRITE
        step(); clear_strobes();
        check("foreign_end_ignored", 32'(sdram_dq_oe), 32'd1);
        write_data_end = 1;
        step(); clear_strobes();
        step();
        check("w_end_oe", 32'(sdram_dq_oe), 32'd0);

        // Refresh beats write when raised together
        ref_req = 1; w_req = 1;
        step();
        check("ref_first", 32'(ref_en), 32'd1);
        ref_req = 0;
        step();
        step();
        check("ref_cmd_on_pins", 32'(pins()), 32'h04000);
        ref_end = 1;
        step(); clear_strobes();
        step();
        check("w_after_ref", 32'(w_en), 32'd1);
        w_req = 0;
        // Refresh during write waits for the break strobe
        ref_req = 1;
        for (int i = 0; i < 3; i++) step();
        check("no_ref_in_write", 32'(ref_en), 32'd0);
        write_ref_break_end = 1; w_req = 1;
        step(); clear_strobes();
        step();
        check("ref_after_break", 32'(ref_en), 32'd1);
        ref_req = 0;
        step();
        ref_end = 1;
        step(); clear_strobes();
        step();
        check("w_regrant", 32'(w_en), 32'd1);
        w_req = 0;
        step();
        // Reset mid-write
        rst = 1;
        step();
        check("rst_mid_cmd", 32'(pins()), 32'(NOP));
        check("rst_mid_oe", 32'(sdram_dq_oe), 32'd0);
        rst = 0;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst                 = ($urandom_range(0, 299) == 0);
            init_end            = ($urandom_range(0, 39) != 0);
            ref_req             = ($urandom_range(0, 5) == 0);
            w_req               = ($urandom_range(0, 2) == 0);
            r_req               = ($urandom_range(0, 2) == 0);
            ref_end             = ($urandom_range(0, 4) == 0);
            write_data_end      = ($urandom_range(0, 5) == 0);
            write_ref_break_end = ($urandom_range(0, 7) == 0);
            read_data_end       = ($urandom_range(0, 5) == 0);
            read_ref_break_end  = ($urandom_range(0, 7) == 0);
            init_cmd            = 18'($urandom);
            ref_cmd             = 18'($urandom);
            w_cmd               = 18'($urandom);
            r_cmd               = 18'($urandom);
            w_dq                = DQ_W'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_arbit.md
# sdram_arbit

Command arbiter between the SDRAM sub-controllers and the SDRAM pins. It sits directly downstream of the init, auto-refresh, write and read engines. It grants one engine at a time via a request/enable handshake and registers the granted engine's 18-bit command and write data onto the SDRAM bus. Priority is refresh > write > read, and an engine keeps ownership until it signals its end strobe.

## Interface
Parameters:
- DQ_W, 16, SDRAM data width
- NOP_CMD, 18'h1c000, idle command {cs_n,ras_n,cas_n,we_n,ba[1:0],addr[11:0]}

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock, shared by all SDRAM engines
- rst  in  1  synchronous active-high reset
- init_end  in  1  level; power-up init sequence complete
- init_cmd  in  18  init engine command
- ref_req  in  1  level from refresh timer; held until ref_en is seen
- ref_en  out  1  one-cycle grant to refresh engine
- ref_cmd  in  18  refresh engine command
- ref_end  in  1  one-cycle pulse; refresh burst done
- w_req  in  1  level from write engine; held until w_en is seen
- w_en  out  1  one-cycle grant to write engine
- w_cmd  in  18  write engine command
- w_dq  in  DQ_W  write data from write engine
- write_ref_break_end  in  1  pulse; write aborted at burst boundary for refresh, precharge done
- write_data_end  in  1  pulse; write finished its row, precharge done
- r_req  in  1  level from read engine
- r_en  out  1  one-cycle grant to read engine
- r_cmd  in  18  read engine command
- read_ref_break_end  in  1  pulse; read aborted for refresh
- read_data_end  in  1  pulse; read row complete
- sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  out  1 each  command pins
- sdram_ba  out  2  bank address
- sdram_addr  out  12  row/column address
- sdram_dq_out  out  DQ_W  write data to the DQ tristate buffer
- sdram_dq_oe  out  1  DQ output enable

## Operation
- FSM states: INIT, ARBIT, AREF, WRITE, READ (one-hot, 5 bits). Reset state is INIT.
- INIT -> ARBIT when init_end = 1.
- ARBIT evaluates requests in priority order:
  - ref_req -> AREF
  - else w_req -> WRITE
  - else r_req -> READ
  - else stay in ARBIT.
- Exit conditions, each returning to ARBIT:
  - AREF on ref_end
  - WRITE on write_data_end or write_ref_break_end
  - READ on read_data_end or read_ref_break_end
- Only the end strobes of the owning engine are honoured. Strobes from other engines are ignored.
- Grants are registered and asserted for exactly one cycle, on the same edge the FSM leaves ARBIT:
  - ref_en <= ARBIT & ref_req
  - w_en <= ARBIT & !ref_req & w_req
  - r_en <= ARBIT & !ref_req & !w_req & r_req
- At most one grant is high in any cycle.
- The command mux is registered. The command bus selects by state:
  - INIT: init_cmd
  - AREF: ref_cmd
  - WRITE: w_cmd
  - READ: r_cmd
  - ARBIT: NOP_CMD
- The command bus splits onto pins as [17] cs_n, [16] ras_n, [15] cas_n, [14] we_n, [13:12] ba, [11:0] addr.
- sdram_dq_out <= w_dq and sdram_dq_oe <= (state == WRITE). These share the command register stage, so the engine's own cmd/data alignment is preserved.
- Refresh preemption is done by the engines, not by this block:
  - ref_req is wired at top level to the write and read engines.
  - The engines break at a burst boundary and return their *_ref_break_end strobe.
  - The FSM then re-enters ARBIT and the pending ref_req wins.

## Timing
- Reset values:
  - state INIT
  - ref_en, w_en, r_en = 0
  - command pins = NOP_CMD (cs_n = 0, ras_n/cas_n/we_n = 1, ba = 0, addr = 0)
  - sdram_dq_out = 0, sdram_dq_oe = 0
- Reset mid-operation returns to INIT within one cycle and forces NOP on the next edge. Any in-flight grant is dropped.
- Command latency: engine cmd at cycle N appears on the pins at cycle N+1.
- End strobe at cycle N -> ARBIT at N+1 -> grant at N+2 at earliest. The pins carry NOP during the ARBIT cycle.
- Simultaneous ref_req and w_req in ARBIT: AREF granted. w_req stays pending and is granted after ref_end.
- An end strobe in the same cycle as a new request: the block passes through ARBIT first and never hops directly between owners.
- A request deasserted before its grant: no grant; remain in ARBIT.
- If init_end is low, requests are ignored indefinitely.

## Test plan
- Reset, then init_end = 1 at cycle 10 -> pins NOP at reset. INIT passes init_cmd 18'h08400 to the pins one cycle later. ARBIT reached at cycle 11.
- w_req = 1 alone in ARBIT -> w_en high for exactly 1 cycle. w_cmd 18'h10004 appears on the pins one cycle later with dq_oe = 1. write_data_end -> ARBIT, dq_oe = 0.
- ref_req and w_req raised together -> ref_en only. ref_cmd 18'h04000 reaches the pins. After ref_end, w_en pulses 2 cycles later.
- ref_req during WRITE -> no ref_en until write_ref_break_end. Then ARBIT, then ref_en. After ref_end, w_req is granted again.
- read_data_end pulsed while in WRITE -> ignored; state stays WRITE.
- rst asserted while in WRITE -> next cycle state INIT, all pins NOP, dq_oe = 0, no grants.
